// File: rtl/nmi_rr_arbiter_pkg.sv
// Shared types and constants for the nmi round-robin arbiter.
package nmi_arb_pkg;
  localparam int          MAX_MST           = 4;
  localparam int          IDX_W             = 2;
  localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Request-side payload of one nmi port, muxed as a unit.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } nmi_req_t;
endpackage

// File: rtl/nmi_rr_arbiter_if.sv
// Native memory interface: one request/ready handshake per transaction.
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/nmi_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: nearest requesting index at or after ptr.
module rr_pick import nmi_arb_pkg::*; #(
  parameter int NUM_MST = 2
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);
  int best;

  // Keep the requester with the smallest upward (wrapping) distance from ptr.
  always_comb begin
    gnt_idx = '0;
    best    = NUM_MST;
    for (int i = 0; i < NUM_MST; i++) begin
      if (req[i] && ((i + NUM_MST - int'(ptr)) % NUM_MST) < best) begin
        best    = (i + NUM_MST - int'(ptr)) % NUM_MST;
        gnt_idx = IDX_W'(i);
      end
    end
  end

  assign any_req = |req;
endmodule

// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one nmi slave among NUM_MST requesters,
// one transaction per grant, with a watchdog that aborts stuck transfers.
module nmi_rr_arbiter import nmi_arb_pkg::*; #(
  parameter int          NUM_MST       = 2,
  parameter int          TIMEOUT_CYC   = 256,
  parameter logic [31:0] TIMEOUT_RDATA = DEF_TIMEOUT_RDATA
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  nmi_if.slave             mst [NUM_MST],
  nmi_if.master            slv,
  input  logic             err_clr_i,
  output logic             err_o,
  output logic [IDX_W-1:0] err_id_o
);
  localparam int               WDT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit               WDT_EN   = (TIMEOUT_CYC > 0);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYC - 1);

  arb_state_e         state;
  logic [IDX_W-1:0]   grant_q, rr_ptr, pick_idx;
  logic [WDT_W-1:0]   wdt;
  logic               any_req, busy, sel_vld, abort, txn_end;
  logic [NUM_MST-1:0] req_vld, own;
  nmi_req_t           req [NUM_MST];
  nmi_req_t           sel;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_MST - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  assign busy = (state == ARB_BUSY);

  // Per-port unpack; only the owner of a BUSY grant sees ready/rdata.
  for (genvar i = 0; i < NUM_MST; i++) begin : g_mst
    assign req_vld[i]   = mst[i].valid;
    assign req[i]       = '{addr: mst[i].addr, wdata: mst[i].wdata, wstrb: mst[i].wstrb};
    assign own[i]       = busy && (grant_q == IDX_W'(i));
    assign mst[i].ready = own[i] && (slv.ready || abort);
    assign mst[i].rdata = !own[i] ? '0 : (abort ? TIMEOUT_RDATA : slv.rdata);
  end

  rr_pick #(.NUM_MST(NUM_MST)) u_pick (
    .req     (req_vld),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  // Mux the granted requester onto the slave side; everything is zero in IDLE.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (own[i]) begin
        sel     = req[i];
        sel_vld = req_vld[i];
      end
    end
  end

  // A ready in the last watchdog cycle is a normal completion, not an abort.
  assign abort   = WDT_EN && sel_vld && !slv.ready && (wdt == WDT_LAST);
  assign txn_end = busy && (!sel_vld || slv.ready || abort);

  assign slv.valid = sel_vld && !abort;
  assign slv.addr  = sel.addr;
  assign slv.wdata = sel.wdata;
  assign slv.wstrb = sel.wstrb;

  // Arbitration FSM: grant in IDLE, hold for one transaction, then rotate.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      wdt     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q <= pick_idx;
            state   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (txn_end) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_idx(grant_q);
            wdt    <= '0;
          end else begin
            wdt <= wdt + WDT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Sticky abort flag; a fresh abort overrides a coincident clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_o    <= 1'b0;
      err_id_o <= '0;
    end else if (abort) begin
      err_o    <= 1'b1;
      err_id_o <= grant_q;
    end else if (err_clr_i) begin
      err_o    <= 1'b0;
      err_id_o <= '0;
    end
  end
endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Directed plus randomized bench for nmi_rr_arbiter (3 requesters, 16-cycle watchdog).
module tb_nmi_rr_arbiter;
  logic        clk, rst_n, err_clr;
  wire         err;
  wire  [1:0]  err_id;
  logic [2:0]  m_valid;
  logic [31:0] m_addr [3];
  logic [31:0] m_wdata [3];
  logic [3:0]  m_wstrb [3];
  wire  [2:0]  m_ready;
  wire  [31:0] m_rdata [3];
  logic        s_ready;
  logic [31:0] s_rdata;
  int          n_assert, n_fail;

  nmi_if mst_if [3] ();
  nmi_if slv_if ();

  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign mst_if[g].valid = m_valid[g];
    assign mst_if[g].addr  = m_addr[g];
    assign mst_if[g].wdata = m_wdata[g];
    assign mst_if[g].wstrb = m_wstrb[g];
    assign m_ready[g]      = mst_if[g].ready;
    assign m_rdata[g]      = mst_if[g].rdata;
  end
  assign slv_if.ready = s_ready;
  assign slv_if.rdata = s_rdata;

  nmi_rr_arbiter #(.NUM_MST(3), .TIMEOUT_CYC(16)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .mst       (mst_if),
    .slv       (slv_if),
    .err_clr_i (err_clr),
    .err_o     (err),
    .err_id_o  (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m_valid = '0; s_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference arbitration rule: first valid index at or after p, wrapping.
  function automatic int rr_ref(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  initial begin
    int ng, bw, last, cur, ptr, s_cnt, s_wait, done_pend, n_done;
    n_assert = 0; n_fail = 0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = 32'hFFFF_FFF0 | i; m_wdata[i] = '1; m_wstrb[i] = '1;
    end
    s_rdata = 32'hFFFF_FFFF;

    // Reset state: every port output zero even with garbage on the inputs.
    do_reset();
    @(negedge clk);
    chk("rst slv_valid", 32'(slv_if.valid), 0);
    chk("rst slv_addr", slv_if.addr, 0);
    chk("rst slv_wdata", slv_if.wdata, 0);
    chk("rst slv_wstrb", 32'(slv_if.wstrb), 0);
    chk("rst mst_ready", 32'(m_ready), 0);
    for (int i = 0; i < 3; i++) chk("rst mst_rdata", m_rdata[i], 0);
    chk("rst err", 32'(err), 0);
    chk("rst err_id", 32'(err_id), 0);

    // Single write on mst[0], zero-wait slave.
    @(posedge clk); #1;
    m_addr[0] = 32'h0000_1000; m_wdata[0] = 32'h1234_5678; m_wstrb[0] = 4'hF;
    m_valid[0] = 1'b1; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("single idle valid", 32'(slv_if.valid), 0);
    @(negedge clk);
    chk("single valid", 32'(slv_if.valid), 1);
    chk("single addr", slv_if.addr, 32'h0000_1000);
    chk("single wdata", slv_if.wdata, 32'h1234_5678);
    chk("single wstrb", 32'(slv_if.wstrb), 32'hF);
    chk("single ready", 32'(m_ready), 32'b001);
    chk("single rdata", m_rdata[0], 32'h0BAD_F00D);
    chk("single err", 32'(err), 0);
    @(posedge clk); #1 m_valid[0] = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    chk("single bubble", 32'(slv_if.valid), 0);

    // Fairness: all valid, slave with two wait states.
    do_reset();
    for (int i = 0; i < 3; i++) begin m_addr[i] = 32'(i) << 8; m_wdata[i] = 32'(i); end
    m_valid = 3'b111;
    ng = 0; bw = 0; last = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      @(negedge clk);
      if (slv_if.valid && s_ready) begin
        chk("fair order", 32'(slv_if.addr[9:8]), 32'(ng % 3));
        chk("fair ready", 32'(m_ready), 32'(1 << (ng % 3)));
        if (ng > 0) chk("fair period", 32'(c - last), 4);
        ng++; last = c; bw = 0;
      end else if (slv_if.valid) bw++;
      @(posedge clk); #1 s_ready = (bw >= 2);
    end
    chk("fair count", 32'(ng), 6);

    // Watchdog abort on mst[1].
    do_reset();
    m_addr[1] = 32'h0000_2000; m_wstrb[1] = 4'h0; m_valid[1] = 1'b1;
    @(negedge clk);
    for (int b = 1; b <= 16; b++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (b < 16) begin
        chk("wdt busy valid", 32'(slv_if.valid), 1);
        chk("wdt early ready", 32'(m_ready), 0);
      end else begin
        chk("wdt abort ready", 32'(m_ready), 32'b010);
        chk("wdt abort rdata", m_rdata[1], 32'hDEAD_BEEF);
        chk("wdt abort slv_valid", 32'(slv_if.valid), 0);
        chk("wdt err not yet", 32'(err), 0);
      end
    end
    @(posedge clk); #1 m_valid[1] = 1'b0;
    @(negedge clk);
    chk("wdt err", 32'(err), 1);
    chk("wdt err_id", 32'(err_id), 1);

    // Error clear, then clear coincident with an abort on mst[0].
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr err", 32'(err), 0);
    chk("clr err_id", 32'(err_id), 0);
    @(posedge clk); #1 m_addr[0] = 32'h0000_3000; m_valid[0] = 1'b1;
    @(negedge clk);
    for (int b = 1; b <= 16; b++) begin
      @(posedge clk); #1;
      if (b == 16) err_clr = 1'b1;
      @(negedge clk);
      if (b == 16) chk("clr+abort ready", 32'(m_ready), 32'b001);
    end
    @(posedge clk); #1 err_clr = 1'b0; m_valid[0] = 1'b0;
    @(negedge clk);
    chk("clr+abort err", 32'(err), 1);
    chk("clr+abort err_id", 32'(err_id), 0);
    // The abort on mst[0] moved the pointer to 1, so 2 beats 0 next.
    @(posedge clk); #1;
    m_addr[2] = 32'h0000_5000; m_valid = 3'b101; s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort advances ptr", slv_if.addr, 32'h0000_5000);
    @(posedge clk); #1 m_valid = '0; s_ready = 1'b0;

    // Ready arriving in the final watchdog cycle completes normally.
    do_reset();
    m_addr[1] = 32'h0000_2000; m_valid[1] = 1'b1;
    @(negedge clk);
    for (int b = 1; b <= 16; b++) begin
      @(posedge clk); #1;
      if (b == 16) begin s_ready = 1'b1; s_rdata = 32'hA5A5_A5A5; end
      @(negedge clk);
      if (b == 16) begin
        chk("limit ready", 32'(m_ready), 32'b010);
        chk("limit rdata", m_rdata[1], 32'hA5A5_A5A5);
        chk("limit slv_valid", 32'(slv_if.valid), 1);
      end
    end
    @(posedge clk); #1 m_valid[1] = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    chk("limit err", 32'(err), 0);

    // Reset in the middle of a transaction with the pointer away from 0.
    do_reset();
    m_addr[1] = 32'h0000_1100; m_valid[1] = 1'b1; s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid pre ready", 32'(m_ready), 32'b010);
    @(posedge clk); #1;
    m_valid[1] = 1'b0; s_ready = 1'b0; m_addr[2] = 32'h0000_1200; m_valid[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid busy valid", 32'(slv_if.valid), 1);
    chk("mid busy addr", slv_if.addr, 32'h0000_1200);
    #2 s_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("mid async valid", 32'(slv_if.valid), 0);
    chk("mid async ready", 32'(m_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_addr[0] = 32'h0000_1000; m_addr[1] = 32'h0000_1100; m_valid = 3'b111;
    @(negedge clk);
    chk("mid post idle", 32'(slv_if.valid), 0);
    @(negedge clk);
    chk("mid post grant", slv_if.addr, 32'h0000_1000);
    chk("mid post ready", 32'(m_ready), 32'b001);
    @(posedge clk); #1 m_valid = '0; s_ready = 1'b0;

    // Random traffic against the reference rule.
    do_reset();
    cur = -1; ptr = 0; s_cnt = 0; s_wait = $urandom_range(0, 3); done_pend = -1; n_done = 0;
    s_rdata = $urandom;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (done_pend >= 0) begin
        m_valid[done_pend] = 1'b0;
        s_cnt = 0; s_wait = $urandom_range(0, 3); s_rdata = $urandom;
        done_pend = -1;
      end
      for (int i = 0; i < 3; i++) begin
        if (!m_valid[i] && $urandom_range(0, 2) == 0) begin
          m_valid[i] = 1'b1; m_addr[i] = $urandom; m_wdata[i] = $urandom; m_wstrb[i] = 4'($urandom);
        end
      end
      s_ready = (s_cnt >= s_wait);
      @(negedge clk);
      if (cur < 0) begin
        chk("rnd idle valid", 32'(slv_if.valid), 0);
        chk("rnd idle ready", 32'(m_ready), 0);
        if (|m_valid) cur = rr_ref(m_valid, ptr);
      end else begin
        chk("rnd valid", 32'(slv_if.valid), 1);
        chk("rnd addr", slv_if.addr, m_addr[cur]);
        chk("rnd wdata", slv_if.wdata, m_wdata[cur]);
        chk("rnd wstrb", 32'(slv_if.wstrb), 32'(m_wstrb[cur]));
        for (int i = 0; i < 3; i++) begin
          chk("rnd mst_ready", 32'(m_ready[i]), (i == cur) ? 32'(s_ready) : 0);
          chk("rnd mst_rdata", m_rdata[i], (i == cur) ? s_rdata : 0);
        end
        if (s_ready) begin
          ptr = (cur + 1) % 3; done_pend = cur; n_done++; cur = -1;
        end else s_cnt++;
      end
    end
    chk("rnd err", 32'(err), 0);
    chk("rnd progress", 32'(n_done > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
